// File: rtl/c1541_gcr_stream_pkg.sv
// Shared constants and types for the 1541 GCR media stream.
// Bit-cell period is (ZONE_BASE - zone) * ZONE_SCALE clk32 cycles.
package c1541_pkg;

  localparam int ZONE_BASE      = 16;
  localparam int ZONE_SCALE     = 8;
  localparam int BYTE_PULSE_DEF = 32;
  localparam int SYNC_ONES_DEF  = 10;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } gcr_mode_t;

  function automatic logic [7:0] zone_period(input logic [1:0] zone);
    return 8'((ZONE_BASE - int'(zone)) * ZONE_SCALE);
  endfunction

endpackage

// File: rtl/c1541_gcr_stream_bit_timer.sv
// Zone-dependent bit-cell timer producing a one-cycle bit_tick.
// The zone is sampled when a cell starts, so a running cell keeps its old length.
module c1541_bit_timer
  import c1541_pkg::*;
(
  input  logic       clk32,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] speed_zone,
  output logic       bit_tick
);

  logic [7:0] cnt;
  logic [1:0] zone_q;
  logic [1:0] zone_eff;

  assign zone_eff = (cnt == 8'd0) ? speed_zone : zone_q;
  assign bit_tick = run && (cnt == zone_period(zone_eff) - 8'd1);

  always_ff @(posedge clk32) begin
    if (reset) begin
      cnt    <= 8'd0;
      zone_q <= 2'd0;
    end else if (run) begin
      if (cnt == 8'd0) zone_q <= speed_zone;
      cnt <= bit_tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/c1541_gcr_stream.sv
// Track-buffer GCR streamer feeding the 1541 drive logic (din/sync_n/byte_n)
// and writing dout back into the buffer in write mode.
module c1541_gcr_stream
  import c1541_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int BYTE_PULSE = BYTE_PULSE_DEF,
  parameter int SYNC_ONES  = SYNC_ONES_DEF
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              mtr,
  input  logic              mode,
  input  logic              soe,
  input  logic [1:0]        speed_zone,
  input  logic [7:0]        dout,
  output logic [7:0]        din,
  output logic              sync_n,
  output logic              byte_n,
  input  logic [ADDR_W-1:0] track_len,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        buf_wdata,
  output logic              buf_we
);

  localparam int          PW      = $clog2(BYTE_PULSE + 1);
  localparam logic [3:0]  SYNC_TH = 4'(SYNC_ONES);

  logic            run;
  logic            bit_tick;
  gcr_mode_t       mode_q, mode_d;
  logic [2:0]      bit_pos, bit_pos_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [3:0]      ones_cnt, ones_d, ones_inc;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rd_byte;
  logic [7:0]      wr_byte, wr_byte_d;
  logic            wr_valid, wr_valid_d;
  logic [PW-1:0]   pulse_cnt, pulse_d;
  logic [7:0]      din_d;
  logic [ADDR_W-1:0] addr_d, addr_next;
  logic [ADDR_W:0] addr_inc;
  logic            cur_bit;
  logic            byte_done;
  logic            wr_fire;

  assign run = mtr && (track_len != '0);

  c1541_bit_timer u_timer (
    .clk32      (clk32),
    .reset      (reset),
    .run        (run),
    .speed_zone (speed_zone),
    .bit_tick   (bit_tick)
  );

  // bit_pos tracks the head inside the buffer byte; bit_cnt frames the
  // assembled byte and is held at zero while a SYNC mark is being read.
  always_comb begin
    mode_d     = mode_q;
    bit_pos_d  = bit_pos;
    bit_cnt_d  = bit_cnt;
    ones_d     = ones_cnt;
    shift_d    = shift_q;
    din_d      = din;
    addr_d     = buf_addr;
    wr_byte_d  = wr_byte;
    wr_valid_d = wr_valid;
    pulse_d    = (pulse_cnt != '0) ? pulse_cnt - 1'b1 : '0;
    byte_done  = 1'b0;
    wr_fire    = 1'b0;
    cur_bit    = rd_byte[~bit_pos];
    ones_inc   = (ones_cnt == 4'hF) ? 4'hF : ones_cnt + 4'd1;
    addr_inc   = {1'b0, buf_addr} + 1'b1;
    addr_next  = (addr_inc >= {1'b0, track_len}) ? '0 : addr_inc[ADDR_W-1:0];

    if (mode_q == WR) ones_d = 4'd0;

    if (!run) begin
      pulse_d = '0;
    end else if (bit_tick) begin
      bit_pos_d = bit_pos + 3'd1;
      if (mode_q == RD) begin
        ones_d  = cur_bit ? ones_inc : 4'd0;
        shift_d = {shift_q[6:0], cur_bit};
        if (ones_d >= SYNC_TH) begin
          bit_cnt_d = 3'd0;
        end else if (bit_cnt == 3'd7) begin
          bit_cnt_d = 3'd0;
          din_d     = shift_d;
          byte_done = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt + 3'd1;
        end
      end else begin
        bit_cnt_d = bit_pos + 3'd1;
        if (bit_pos == 3'd7) begin
          byte_done  = 1'b1;
          wr_fire    = wr_valid;
          wr_byte_d  = dout;
          wr_valid_d = 1'b1;
        end
      end

      if (bit_pos == 3'd7) begin
        addr_d = addr_next;
        mode_d = mode ? RD : WR;
        if (mode_d != mode_q) begin
          bit_cnt_d  = 3'd0;
          wr_valid_d = 1'b0;
        end
      end

      if (byte_done && soe) pulse_d = PW'(BYTE_PULSE);
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      mode_q    <= mode ? RD : WR;
      bit_pos   <= 3'd0;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 4'd0;
      shift_q   <= 8'h00;
      rd_byte   <= 8'h00;
      wr_byte   <= 8'h00;
      wr_valid  <= 1'b0;
      pulse_cnt <= '0;
      din       <= 8'h00;
      buf_addr  <= '0;
    end else begin
      mode_q    <= mode_d;
      bit_pos   <= bit_pos_d;
      bit_cnt   <= bit_cnt_d;
      ones_cnt  <= ones_d;
      shift_q   <= shift_d;
      rd_byte   <= buf_rdata;
      wr_byte   <= wr_byte_d;
      wr_valid  <= wr_valid_d;
      pulse_cnt <= pulse_d;
      din       <= din_d;
      buf_addr  <= addr_d;
    end
  end

  assign sync_n    = !(run && (mode_q == RD) && (ones_cnt >= SYNC_TH));
  assign byte_n    = !(run && (pulse_cnt != '0));
  assign buf_wdata = wr_byte;
  assign buf_we    = wr_fire && !reset;

endmodule

// File: tb/tb_c1541_gcr_stream.sv
// Directed bench for c1541_gcr_stream: zone timing table, sync, write,
// halt and boundary sequences against a behavioural track buffer.
module tb_c1541_gcr_stream;

  logic        clk32 = 1'b0;
  logic        reset = 1'b0;
  logic        mtr = 1'b0;
  logic        mode = 1'b1;
  logic        soe = 1'b1;
  logic [1:0]  speed_zone = 2'd0;
  logic [7:0]  dout = 8'h00;
  logic [7:0]  din;
  logic        sync_n;
  logic        byte_n;
  logic [12:0] track_len = 13'd0;
  logic [12:0] buf_addr;
  logic [7:0]  buf_rdata = 8'h00;
  logic [7:0]  buf_wdata;
  logic        buf_we;

  logic [7:0]  mem [0:8191];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          we_count = 0;
  logic [7:0]  we_data = 8'h00;
  logic [12:0] we_addr = 13'd0;

  typedef struct {
    logic [1:0] zone;
    int         spacing;
    int         width;
  } zone_vec_t;

  zone_vec_t zvec [4];
  logic [7:0] rd_seq [5];

  c1541_gcr_stream dut (
    .clk32      (clk32),
    .reset      (reset),
    .mtr        (mtr),
    .mode       (mode),
    .soe        (soe),
    .speed_zone (speed_zone),
    .dout       (dout),
    .din        (din),
    .sync_n     (sync_n),
    .byte_n     (byte_n),
    .track_len  (track_len),
    .buf_addr   (buf_addr),
    .buf_rdata  (buf_rdata),
    .buf_wdata  (buf_wdata),
    .buf_we     (buf_we)
  );

  always #5 clk32 = ~clk32;

  always @(posedge clk32) begin
    cyc <= cyc + 1;
    buf_rdata <= mem[buf_addr];
    if (buf_we) mem[buf_addr] <= buf_wdata;
  end

  always @(negedge clk32) begin
    if (buf_we) begin
      we_count = we_count + 1;
      we_data  = buf_wdata;
      we_addr  = buf_addr;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic md, input logic s,
                               input logic [1:0] z, input logic [12:0] tl,
                               input logic [7:0] d);
    mtr = m; mode = md; soe = s; speed_zone = z; track_len = tl; dout = d;
  endtask

  task automatic load_mem(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
  endtask

  task automatic do_reset();
    @(negedge clk32);
    reset = 1'b1;
    repeat (2) @(negedge clk32);
    reset = 1'b0;
  endtask

  task automatic wait_byte(input int budget, output int t);
    logic prev;
    prev = byte_n;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk32);
      if (prev && !byte_n) begin
        t = cyc;
        break;
      end
      prev = byte_n;
    end
    if (t < 0) begin
      total++; bad++;
      $display("[TB] FAIL byte_timeout: no byte_n fall within %0d cycles", budget);
    end
  endtask

  task automatic pulse_width(output int w);
    w = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk32);
      if (byte_n) break;
      w++;
    end
  endtask

  task automatic wait_sync(input logic level, input int budget,
                           output int t, output int lows);
    t = -1;
    lows = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk32);
      if (!byte_n) lows++;
      if (sync_n == level) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      total++; bad++;
      $display("[TB] FAIL sync_timeout: sync_n never reached %0b", level);
    end
  endtask

  initial begin
    int t0, t1, w, ts0, ts1, lows;
    logic [12:0] a;

    zvec[0] = '{zone: 2'd3, spacing: 832,  width: 32};
    zvec[1] = '{zone: 2'd2, spacing: 896,  width: 32};
    zvec[2] = '{zone: 2'd1, spacing: 960,  width: 32};
    zvec[3] = '{zone: 2'd0, spacing: 1024, width: 32};
    rd_seq[0] = 8'h55; rd_seq[1] = 8'hAA; rd_seq[2] = 8'h12;
    rd_seq[3] = 8'h34; rd_seq[4] = 8'h55;

    // Reset state
    load_mem(8'h55, 8'hAA, 8'h12, 8'h34);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 13'd4, 8'h00);
    do_reset();
    @(negedge clk32);
    checkOutput("rst_din", din, 8'h00);
    checkOutput("rst_sync_n", sync_n, 1);
    checkOutput("rst_byte_n", byte_n, 1);
    checkOutput("rst_addr", buf_addr, 0);
    checkOutput("rst_we", buf_we, 0);
    checkOutput("rst_wdata", buf_wdata, 8'h00);

    // Zone timing table
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, zvec[v].zone, 13'd4, 8'h00);
      do_reset();
      mtr = 1'b1;
      wait_byte(3000, t0);
      checkOutput($sformatf("z%0d_din0", zvec[v].zone), din, rd_seq[0]);
      checkOutput($sformatf("z%0d_addr1", zvec[v].zone), buf_addr, 1);
      pulse_width(w);
      checkOutput($sformatf("z%0d_width", zvec[v].zone), w, zvec[v].width);
      for (int b = 1; b < 5; b++) begin
        wait_byte(3000, t1);
        checkOutput($sformatf("z%0d_din%0d", zvec[v].zone, b), din, rd_seq[b]);
        checkOutput($sformatf("z%0d_gap%0d", zvec[v].zone, b), t1 - t0, zvec[v].spacing);
        t0 = t1;
      end
    end

    // Sync detection
    load_mem(8'hFF, 8'hFF, 8'h52, 8'h33);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 13'd4, 8'h00);
    do_reset();
    mtr = 1'b1;
    wait_byte(3000, t0);
    checkOutput("sync_pre_din", din, 8'hFF);
    wait_sync(1'b0, 3000, ts0, lows);
    checkOutput("sync_fall_time", ts0 - t0, 208);
    wait_sync(1'b1, 3000, ts1, lows);
    checkOutput("sync_rise_time", ts1 - ts0, 728);
    checkOutput("sync_no_byte", lows, 0);
    wait_byte(3000, t1);
    checkOutput("sync_post_time", t1 - ts0, 1456);
    checkOutput("sync_post_din", din, 8'h52);

    // Write path
    load_mem(8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 13'd4, 8'hA5);
    do_reset();
    we_count = 0;
    mtr = 1'b1;
    wait_byte(3000, t0);
    checkOutput("wr1_we_count", we_count, 0);
    checkOutput("wr1_addr", buf_addr, 1);
    dout = 8'h3C;
    wait_byte(3000, t1);
    checkOutput("wr2_we_count", we_count, 1);
    checkOutput("wr2_data", we_data, 8'hA5);
    checkOutput("wr2_waddr", we_addr, 1);
    checkOutput("wr2_addr", buf_addr, 2);
    checkOutput("wr2_mem", mem[1], 8'hA5);
    wait_byte(3000, t1);
    checkOutput("wr3_we_count", we_count, 2);
    checkOutput("wr3_data", we_data, 8'h3C);
    checkOutput("wr3_waddr", we_addr, 2);
    checkOutput("wr3_sync_n", sync_n, 1);

    // Reset asserted in the very cycle a write is due
    t1 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk32);
      if (buf_we) begin
        t1 = cyc;
        break;
      end
    end
    checkOutput("rstwr_found", (t1 >= 0) ? 1 : 0, 1);
    a = buf_addr;
    reset = 1'b1;
    #1;
    checkOutput("rstwr_we_gated", buf_we, 0);
    @(negedge clk32);
    checkOutput("rstwr_mem", mem[a], 8'h00);
    checkOutput("rstwr_din", din, 8'h00);
    checkOutput("rstwr_sync_n", sync_n, 1);
    checkOutput("rstwr_byte_n", byte_n, 1);
    checkOutput("rstwr_addr", buf_addr, 0);
    checkOutput("rstwr_we", buf_we, 0);
    checkOutput("rstwr_wdata", buf_wdata, 8'h00);
    reset = 1'b0;

    // Halt mid-pulse and resume
    load_mem(8'h55, 8'hAA, 8'h12, 8'h34);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 13'd4, 8'h00);
    do_reset();
    mtr = 1'b1;
    wait_byte(3000, t0);
    repeat (10) @(negedge clk32);
    mtr = 1'b0;
    @(negedge clk32);
    checkOutput("halt_byte_n", byte_n, 1);
    checkOutput("halt_sync_n", sync_n, 1);
    checkOutput("halt_addr_a", buf_addr, 1);
    lows = 0;
    repeat (398) begin
      @(negedge clk32);
      if (!byte_n) lows++;
    end
    checkOutput("halt_addr_b", buf_addr, 1);
    checkOutput("halt_no_byte", lows, 0);
    @(negedge clk32);
    mtr = 1'b1;
    wait_byte(3000, t1);
    checkOutput("halt_resume_din", din, 8'hAA);
    checkOutput("halt_resume_gap", t1 - t0, 832 + 400);

    // track_len = 0: timer never ticks
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 13'd0, 8'h00);
    do_reset();
    lows = 0;
    repeat (1200) begin
      @(negedge clk32);
      if (dut.bit_tick) lows++;
    end
    checkOutput("notrack_ticks", lows, 0);
    checkOutput("notrack_addr", buf_addr, 0);
    checkOutput("notrack_byte_n", byte_n, 1);

    // soe = 0: din updates, byte_n stays high
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 13'd4, 8'h00);
    do_reset();
    mtr = 1'b1;
    lows = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk32);
      if (!byte_n) lows++;
      if (din != 8'h00) break;
    end
    checkOutput("nosoe_din0", din, 8'h55);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk32);
      if (!byte_n) lows++;
      if (din != 8'h55) break;
    end
    checkOutput("nosoe_din1", din, 8'hAA);
    checkOutput("nosoe_byte_n", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
